// File: rtl/fp_pkg.sv
// Shared FP divider types: rounding modes, flag indices, precision constants, FSM states.
package fp_pkg;

  typedef enum logic [1:0] {RM_RNE = 2'd0, RM_RZ = 2'd1, RM_RU = 2'd2, RM_RD = 2'd3} rm_e;
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_ROUND, S_DONE} state_e;

  localparam int FLG_INV = 4;
  localparam int FLG_DZ  = 3;
  localparam int FLG_OV  = 2;
  localparam int FLG_UN  = 1;
  localparam int FLG_NX  = 0;

  localparam int SP_EXP_W  = 8;
  localparam int SP_FRAC_W = 23;
  localparam int DP_EXP_W  = 11;
  localparam int DP_FRAC_W = 52;
  localparam int SP_BIAS   = 127;
  localparam int DP_BIAS   = 1023;
  localparam int SP_WRAP   = 192;
  localparam int DP_WRAP   = 1536;
  localparam int SP_ITERS  = 7;
  localparam int DP_ITERS  = 14;

  // Single-precision mantissas are left-aligned into the double datapath.
  localparam int MANT_W = DP_FRAC_W + 1;
  localparam int REM_W  = MANT_W + 2;
  localparam int QUO_W  = 4 * DP_ITERS;

  localparam logic [63:0] SP_QNAN = 64'h7FC00000_00000000;
  localparam logic [63:0] DP_QNAN = 64'h7FF80000_00000000;

  function automatic rm_e decode_rm(input logic [2:0] rm);
    return rm[2] ? RM_RNE : rm_e'(rm[1:0]);
  endfunction

  function automatic logic [63:0] pack_fp(input logic p, input logic s,
                                          input logic [10:0] e, input logic [51:0] f);
    return p ? {s, e[7:0], f[51:29], 32'b0} : {s, e, f};
  endfunction

endpackage

// File: rtl/fpdiv_if.sv
// Operand/result bus of the FP divider with start/done handshake.
interface fpdiv_if;
  logic [63:0]  op1;
  logic [63:0]  op2;
  logic [2:0]   rm;
  logic         op_type;
  logic         P;
  logic         OvEn;
  logic         UnEn;
  logic         start;
  logic         done;
  logic [63:0]  AS_Result;
  logic [4:0]   Flags;
  logic         Denorm;
  logic [127:0] regr_out;

  modport master (output op1, op2, rm, op_type, P, OvEn, UnEn, start,
                  input  done, AS_Result, Flags, Denorm, regr_out);
  modport slave  (input  op1, op2, rm, op_type, P, OvEn, UnEn, start,
                  output done, AS_Result, Flags, Denorm, regr_out);
endinterface

// File: rtl/fpdiv_iter.sv
// Four restoring-division steps per cycle: compare, subtract, shift.
module fpdiv_iter
  import fp_pkg::*;
(
  input  logic [REM_W-1:0]  rem,
  input  logic [MANT_W-1:0] div,
  output logic [REM_W-1:0]  rem_nxt,
  output logic [3:0]        qbits
);

  logic [REM_W-1:0] r;

  always_comb begin
    r     = rem;
    qbits = '0;
    for (int i = 3; i >= 0; i--) begin
      if (r >= {2'b0, div}) begin
        r        = r - {2'b0, div};
        qbits[i] = 1'b1;
      end
      // after a step r < div, so the top bit shifted out is always zero
      r = {r[REM_W-2:0], 1'b0};
    end
    rem_nxt = r;
  end

endmodule

// File: rtl/fpdiv.sv
// Iterative IEEE-754 single/double divider: PREP unpack, 4 bits/cycle ITER, ROUND/pack.
module fpdiv
  import fp_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  fpdiv_if.slave bus
);

  state_e             state;
  logic               start_q;
  logic [63:0]        a_q, b_q;
  rm_e                rm_q;
  logic               op_q, p_q, oven_q, unen_q;

  logic               sign_q;
  logic signed [13:0] exp_q;
  logic [MANT_W-1:0]  div_q;
  logic [REM_W-1:0]   rem_q;
  logic [QUO_W-1:0]   quo_q;
  logic [3:0]         cnt_q;
  logic               special_q;
  logic [63:0]        spec_res_q;
  logic [4:0]         spec_flg_q;

  logic               done_q, denorm_q;
  logic [63:0]        res_q;
  logic [4:0]         flags_q;
  logic [127:0]       regr_q;

  assign bus.done      = done_q;
  assign bus.AS_Result = res_q;
  assign bus.Flags     = flags_q;
  assign bus.Denorm    = denorm_q;
  assign bus.regr_out  = regr_q;

  wire accept = bus.start & ~start_q & ((state == S_IDLE) | (state == S_DONE));

  // ---------------- unpack / classify ----------------
  logic               sa, sb, s_res;
  logic [10:0]        ea, eb, emax;
  logic [51:0]        fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic               sp_hit;
  logic [63:0]        sp_res;
  logic [4:0]         sp_flg;
  logic signed [13:0] exp_pre;

  always_comb begin
    sa = a_q[63];
    sb = b_q[63];
    if (p_q) begin
      ea = {3'b0, a_q[62:55]};
      eb = {3'b0, b_q[62:55]};
      fa = {a_q[54:32], 29'b0};
      fb = {b_q[54:32], 29'b0};
      emax = 11'h0FF;
    end else begin
      ea = a_q[62:52];
      eb = b_q[62:52];
      fa = a_q[51:0];
      fb = b_q[51:0];
      emax = 11'h7FF;
    end
    s_res  = sa ^ sb;
    // subnormals flush to zero: a zero exponent field means zero regardless of fraction
    a_zero = (ea == 11'd0);
    b_zero = (eb == 11'd0);
    a_nan  = (ea == emax) & (|fa);
    b_nan  = (eb == emax) & (|fb);
    a_snan = a_nan & ~fa[51];
    b_snan = b_nan & ~fb[51];
    a_inf  = (ea == emax) & ~(|fa);
    b_inf  = (eb == emax) & ~(|fb);

    sp_hit = 1'b1;
    sp_flg = '0;
    sp_res = '0;
    if (op_q) begin
      sp_res = p_q ? SP_QNAN : DP_QNAN;
      sp_flg[FLG_INV] = 1'b1;
    end else if (a_nan | b_nan) begin
      sp_res = p_q ? SP_QNAN : DP_QNAN;
      sp_flg[FLG_INV] = a_snan | b_snan;
    end else if ((a_inf & b_inf) | (a_zero & b_zero)) begin
      sp_res = p_q ? SP_QNAN : DP_QNAN;
      sp_flg[FLG_INV] = 1'b1;
    end else if (a_inf) begin
      sp_res = pack_fp(p_q, s_res, 11'h7FF, '0);
    end else if (b_zero) begin
      sp_res = pack_fp(p_q, s_res, 11'h7FF, '0);
      sp_flg[FLG_DZ] = 1'b1;
    end else if (b_inf | a_zero) begin
      sp_res = {s_res, 63'b0};
    end else begin
      sp_hit = 1'b0;
    end

    exp_pre = $signed({3'b0, ea}) - $signed({3'b0, eb})
            + (p_q ? 14'(SP_BIAS) : 14'(DP_BIAS));
  end

  // ---------------- iteration slice ----------------
  logic [REM_W-1:0] it_rem;
  logic [3:0]       it_q;

  fpdiv_iter u_iter (
    .rem     (rem_q),
    .div     (div_q),
    .rem_nxt (it_rem),
    .qbits   (it_q)
  );

  // ---------------- normalize / round / pack ----------------
  logic               q_int, g, s, inc, carry, ovf, unf, to_inf;
  logic [MANT_W-1:0]  mant;
  logic [MANT_W:0]    mant_r;
  logic [51:0]        frac;
  logic signed [13:0] e_r, e_w;
  logic [63:0]        rnd_res;
  logic [4:0]         rnd_flg;
  logic               rnd_den;

  always_comb begin
    q_int = p_q ? quo_q[27] : quo_q[55];
    mant  = '0;
    g     = 1'b0;
    s     = 1'b0;
    if (p_q) begin
      if (quo_q[27]) begin
        mant = {29'b0, quo_q[27:4]}; g = quo_q[3]; s = |quo_q[2:0];
      end else begin
        mant = {29'b0, quo_q[26:3]}; g = quo_q[2]; s = |quo_q[1:0];
      end
    end else begin
      if (quo_q[55]) begin
        mant = quo_q[55:3]; g = quo_q[2]; s = |quo_q[1:0];
      end else begin
        mant = quo_q[54:2]; g = quo_q[1]; s = quo_q[0];
      end
    end
    s = s | (|rem_q);

    case (rm_q)
      RM_RZ:   inc = 1'b0;
      RM_RU:   inc = (g | s) & ~sign_q;
      RM_RD:   inc = (g | s) & sign_q;
      default: inc = g & (s | mant[0]);
    endcase
    mant_r = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
    // a carry-out leaves the fraction field all zero, so only the exponent moves
    carry  = p_q ? mant_r[24] : mant_r[53];
    frac   = p_q ? {mant_r[22:0], 29'b0} : mant_r[51:0];
    e_r    = exp_q - $signed({13'b0, ~q_int}) + $signed({13'b0, carry});
    ovf    = e_r >= (p_q ? 14'sd255 : 14'sd2047);
    unf    = e_r <= 14'sd0;
    to_inf = (rm_q == RM_RNE) | ((rm_q == RM_RU) & ~sign_q) | ((rm_q == RM_RD) & sign_q);

    e_w     = e_r;
    rnd_flg = '0;
    rnd_den = 1'b0;
    rnd_res = pack_fp(p_q, sign_q, e_r[10:0], frac);
    if (special_q) begin
      rnd_res = spec_res_q;
      rnd_flg = spec_flg_q;
    end else if (ovf) begin
      rnd_flg[FLG_OV] = 1'b1;
      rnd_flg[FLG_NX] = 1'b1;
      if (oven_q) begin
        e_w     = e_r - (p_q ? 14'(SP_WRAP) : 14'(DP_WRAP));
        rnd_res = pack_fp(p_q, sign_q, e_w[10:0], frac);
      end else if (to_inf) begin
        rnd_res = pack_fp(p_q, sign_q, 11'h7FF, '0);
      end else begin
        rnd_res = pack_fp(p_q, sign_q, p_q ? 11'h0FE : 11'h7FE, '1);
      end
    end else if (unf) begin
      rnd_flg[FLG_UN] = 1'b1;
      rnd_flg[FLG_NX] = 1'b1;
      rnd_den         = 1'b1;
      if (unen_q) begin
        e_w     = e_r + (p_q ? 14'(SP_WRAP) : 14'(DP_WRAP));
        rnd_res = pack_fp(p_q, sign_q, e_w[10:0], frac);
      end else begin
        rnd_res = {sign_q, 63'b0};
      end
    end else begin
      rnd_flg[FLG_NX] = g | s;
    end
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rm_q       <= RM_RNE;
      op_q       <= 1'b0;
      p_q        <= 1'b0;
      oven_q     <= 1'b0;
      unen_q     <= 1'b0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      div_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      spec_flg_q <= '0;
      done_q     <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
      denorm_q   <= 1'b0;
      regr_q     <= '0;
    end else begin
      start_q <= bus.start;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_q    <= bus.op1;
            b_q    <= bus.op2;
            rm_q   <= decode_rm(bus.rm);
            op_q   <= bus.op_type;
            p_q    <= bus.P;
            oven_q <= bus.OvEn;
            unen_q <= bus.UnEn;
            done_q <= 1'b0;
            state  <= S_PREP;
          end
        end
        S_PREP: begin
          sign_q     <= s_res;
          exp_q      <= exp_pre;
          div_q      <= {1'b1, fb};
          rem_q      <= sp_hit ? '0 : {2'b0, 1'b1, fa};
          quo_q      <= '0;
          cnt_q      <= p_q ? 4'(SP_ITERS) : 4'(DP_ITERS);
          special_q  <= sp_hit;
          spec_res_q <= sp_res;
          spec_flg_q <= sp_flg;
          // specials idle out the iteration count in ROUND to keep latency fixed
          state      <= sp_hit ? S_ROUND : S_ITER;
        end
        S_ITER: begin
          rem_q <= it_rem;
          quo_q <= {quo_q[QUO_W-5:0], it_q};
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state <= S_ROUND;
        end
        S_ROUND: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            res_q    <= rnd_res;
            flags_q  <= rnd_flg;
            denorm_q <= rnd_den;
            regr_q   <= {|rem_q, 63'b0, 8'b0, quo_q};
            done_q   <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv.sv
// Scoreboard bench for fpdiv: expected results queued at issue, compared at done.
module tb_fpdiv;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpdiv_if bus ();

  fpdiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [63:0] res;
    logic [4:0]  flg;
    logic        den;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sp(input logic [31:0] v);
    return {v, 32'b0};
  endfunction

  // Issue one op with start held high through completion, then check against the queue.
  task automatic run(input string tag, input logic p, input logic [63:0] a, input logic [63:0] b,
                     input logic [2:0] rm, input logic ov, input logic un, input logic opt,
                     input logic [63:0] res, input logic [4:0] flg, input logic den);
    exp_t e;
    int   n;
    e.tag = tag; e.res = res; e.flg = flg; e.den = den; e.lat = p ? 9 : 16;
    sbq.push_back(e);
    @(negedge clk);
    bus.op1 = a; bus.op2 = b; bus.rm = rm; bus.P = p;
    bus.OvEn = ov; bus.UnEn = un; bus.op_type = opt;
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, 64'(bus.done), 64'd0);
    // inputs after the accept edge must not matter
    bus.op1 = 64'hDEAD_BEEF_0123_4567; bus.op2 = 64'h0; bus.rm = 3'b001;
    bus.P = ~p; bus.OvEn = ~ov; bus.UnEn = ~un; bus.op_type = 1'b1;
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk); n++; #1;
    end
    e = sbq.pop_front();
    chk({e.tag, "_lat"},  64'(n), 64'(e.lat));
    chk({e.tag, "_res"},  bus.AS_Result, e.res);
    chk({e.tag, "_flg"},  64'(bus.Flags), 64'(e.flg));
    chk({e.tag, "_den"},  64'(bus.Denorm), 64'(e.den));
    repeat (3) @(posedge clk);
    #1 chk({e.tag, "_hold"}, 64'(bus.done), 64'd1);
    @(negedge clk) bus.start = 1'b0;
  endtask

  initial begin
    bus.op1 = '0; bus.op2 = '0; bus.rm = '0; bus.op_type = 1'b0;
    bus.P = 1'b1; bus.OvEn = 1'b0; bus.UnEn = 1'b0; bus.start = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_res",  bus.AS_Result, 64'd0);
    chk("rst_flg",  64'(bus.Flags), 64'd0);
    chk("rst_regr", bus.regr_out[127:64] | bus.regr_out[63:0], 64'd0);
    @(negedge clk) reset = 1'b0;

    run("sp_1_3", 1, sp(32'h3F800000), sp(32'h40400000), 3'd0, 0, 0, 0, sp(32'h3EAAAAAB), 5'b00001, 0);
    chk("sp_1_3_sticky", 64'(bus.regr_out[127]), 64'd1);
    run("sp_6_2", 1, sp(32'h40C00000), sp(32'h40000000), 3'd0, 0, 0, 0, sp(32'h40400000), 5'b00000, 0);
    chk("sp_6_2_sticky", 64'(bus.regr_out[127]), 64'd0);
    run("sp_rz",  1, sp(32'h3F800000), sp(32'h40400000), 3'd1, 0, 0, 0, sp(32'h3EAAAAAA), 5'b00001, 0);
    run("sp_ru",  1, sp(32'h3F800000), sp(32'h40400000), 3'd2, 0, 0, 0, sp(32'h3EAAAAAB), 5'b00001, 0);
    run("sp_rd",  1, sp(32'h3F800000), sp(32'h40400000), 3'd3, 0, 0, 0, sp(32'h3EAAAAAA), 5'b00001, 0);
    run("sp_nrd", 1, sp(32'hBF800000), sp(32'h40400000), 3'd3, 0, 0, 0, sp(32'hBEAAAAAB), 5'b00001, 0);
    run("sp_nru", 1, sp(32'hBF800000), sp(32'h40400000), 3'd2, 0, 0, 0, sp(32'hBEAAAAAA), 5'b00001, 0);
    run("sp_rm4", 1, sp(32'h3F800000), sp(32'h40400000), 3'd4, 0, 0, 0, sp(32'h3EAAAAAB), 5'b00001, 0);
    run("sp_div0", 1, sp(32'h3F800000), sp(32'h00000000), 3'd0, 0, 0, 0, sp(32'h7F800000), 5'b01000, 0);
    run("sp_0_0",  1, sp(32'h00000000), sp(32'h00000000), 3'd0, 0, 0, 0, sp(32'h7FC00000), 5'b10000, 0);
    run("sp_ii",   1, sp(32'h7F800000), sp(32'hFF800000), 3'd0, 0, 0, 0, sp(32'h7FC00000), 5'b10000, 0);
    run("sp_qnan", 1, sp(32'h7FC00001), sp(32'h3F800000), 3'd0, 0, 0, 0, sp(32'h7FC00000), 5'b00000, 0);
    run("sp_snan", 1, sp(32'h3F800000), sp(32'h7F800001), 3'd0, 0, 0, 0, sp(32'h7FC00000), 5'b10000, 0);
    run("sp_inf_x", 1, sp(32'hFF800000), sp(32'h40000000), 3'd0, 0, 0, 0, sp(32'hFF800000), 5'b00000, 0);
    run("sp_x_inf", 1, sp(32'hC0000000), sp(32'h7F800000), 3'd0, 0, 0, 0, sp(32'h80000000), 5'b00000, 0);
    run("sp_subn",  1, sp(32'h00000001), sp(32'h3F800000), 3'd0, 0, 0, 0, sp(32'h00000000), 5'b00000, 0);
    run("sp_optype", 1, sp(32'h3F800000), sp(32'h40000000), 3'd0, 0, 0, 1, sp(32'h7FC00000), 5'b10000, 0);
    run("sp_ovf",    1, sp(32'h7F7FFFFF), sp(32'h3E800000), 3'd0, 0, 0, 0, sp(32'h7F800000), 5'b00101, 0);
    run("sp_ovf_rz", 1, sp(32'h7F7FFFFF), sp(32'h3E800000), 3'd1, 0, 0, 0, sp(32'h7F7FFFFF), 5'b00101, 0);
    run("sp_ovf_en", 1, sp(32'h7F7FFFFF), sp(32'h3E800000), 3'd0, 1, 0, 0, sp(32'h207FFFFF), 5'b00101, 0);
    run("sp_unf",    1, sp(32'h00800000), sp(32'h40000000), 3'd0, 0, 0, 0, sp(32'h00000000), 5'b00011, 1);
    run("sp_unf_en", 1, sp(32'h00800000), sp(32'h40000000), 3'd0, 0, 1, 0, sp(32'h60000000), 5'b00011, 1);

    run("dp_1_3", 0, 64'h3FF0000000000000, 64'h4008000000000000, 3'd0, 0, 0, 0, 64'h3FD5555555555555, 5'b00001, 0);
    run("dp_6_2", 0, 64'h4018000000000000, 64'h4000000000000000, 3'd0, 0, 0, 0, 64'h4008000000000000, 5'b00000, 0);
    run("dp_0_0", 0, 64'h0, 64'h0, 3'd0, 0, 0, 0, 64'h7FF8000000000000, 5'b10000, 0);
    run("dp_div0", 0, 64'hBFF0000000000000, 64'h0, 3'd0, 0, 0, 0, 64'hFFF0000000000000, 5'b01000, 0);

    // reset during ITER: abort with every output cleared
    @(negedge clk);
    bus.op1 = 64'h3FF0000000000000; bus.op2 = 64'h4008000000000000;
    bus.P = 1'b0; bus.rm = 3'd0; bus.op_type = 1'b0; bus.start = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #2;
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_res",  bus.AS_Result, 64'd0);
    chk("abort_flg",  64'({bus.Flags, bus.Denorm}), 64'd0);
    chk("abort_regr", bus.regr_out[127:64] | bus.regr_out[63:0], 64'd0);
    @(negedge clk); bus.start = 1'b0; reset = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("abort_no_result", 64'(bus.done), 64'd0);

    run("post_rst", 1, sp(32'h40C00000), sp(32'h40000000), 3'd0, 0, 0, 0, sp(32'h40400000), 5'b00000, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
